// File: rtl/sram_readout_pkg.sv
// rtl/sram_readout_pkg.sv - shared constants and FSM encoding for the SRAM readout path
package sram_readout_pkg;

    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_WAIT_CYC = 2;
    localparam int WAIT_CNT_W   = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_LATCH = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;
    localparam state_t ST_FIN   = 3'd5;

endpackage

// File: rtl/mcu_strobe_sync.sv
// rtl/mcu_strobe_sync.sv - two-flop synchronizer with one-cycle rising-edge pulse
module mcu_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= strobe;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // High on the first cycle sync2 reads 1
    assign pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/sram_readout.sv
// rtl/sram_readout.sv - SRAM record readout to MCU byte handshake; SRAM_READOUT_CHKSUM_EN adds CHKSUM
module sram_readout
    import sram_readout_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W-1:0] LENGTH,
    input  logic [7:0]        SRAM_DATA_IN,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_OE_N,
    input  logic              MCU_RD,
    output logic [7:0]        MCU_DATA,
    output logic              DATA_RDY,
    output logic              BUSY,
`ifdef SRAM_READOUT_CHKSUM_EN
    output logic [7:0]        CHKSUM,
`endif
    output logic              DONE
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_CYC - 1);
    localparam logic [ADDR_W:0]       FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]       LAST_COUNT = (ADDR_W + 1)'(1);

    state_t                state;
    logic [ADDR_W:0]       remain;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  rd_pulse;

    mcu_strobe_sync u_rd_sync (
        .clk    (CLK),
        .rst_n  (CLR),
        .strobe (MCU_RD),
        .pulse  (rd_pulse)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= ST_IDLE;
            remain    <= '0;
            wait_cnt  <= '0;
            SRAM_ADDR <= '0;
            SRAM_OE_N <= 1'b1;
            MCU_DATA  <= 8'h00;
            DATA_RDY  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
`ifdef SRAM_READOUT_CHKSUM_EN
            CHKSUM    <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        SRAM_ADDR <= START_ADDR;
                        // A zero length means the whole SRAM
                        remain    <= (LENGTH == '0) ? FULL_COUNT : {1'b0, LENGTH};
                        SRAM_OE_N <= 1'b0;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
`ifdef SRAM_READOUT_CHKSUM_EN
                        CHKSUM    <= 8'h00;
`endif
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    MCU_DATA <= SRAM_DATA_IN;
                    DATA_RDY <= 1'b1;
`ifdef SRAM_READOUT_CHKSUM_EN
                    CHKSUM   <= CHKSUM + SRAM_DATA_IN;
`endif
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rd_pulse) begin
                        DATA_RDY <= 1'b0;
                        remain   <= remain - (ADDR_W + 1)'(1);
                        if (remain == LAST_COUNT) begin
                            SRAM_OE_N <= 1'b1;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                            state     <= ST_FIN;
                        end else begin
                            SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
                            state     <= ST_SETUP;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_readout.sv
// tb/tb_sram_readout.sv - directed table-driven bench for sram_readout (optional SRAM_READOUT_CHKSUM_EN)
module tb_sram_readout;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [18:0] start_addr;
    logic [18:0] length;
    logic [7:0]  sram_din;
    logic [18:0] sram_addr;
    logic        oe_n;
    logic        mcu_rd;
    logic [7:0]  mcu_data;
    logic        data_rdy;
    logic        busy;
    logic        done;

    logic        s_start;
    logic [3:0]  s_start_addr;
    logic [3:0]  s_length;
    logic [7:0]  s_din;
    logic [3:0]  s_addr;
    logic        s_oe_n;
    logic        s_rd;
    logic [7:0]  s_data;
    logic        s_rdy;
    logic        s_busy;
    logic        s_done;

`ifdef SRAM_READOUT_CHKSUM_EN
    logic [7:0]  chksum;
    logic [7:0]  s_chksum;
`endif

    logic [7:0]  mem [0:524287];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sram_din = oe_n ? 8'h00 : mem[sram_addr];
    assign s_din    = {4'hC, s_addr};

    sram_readout dut (
        .CLK          (clk),
        .CLR          (clr_n),
        .START        (start),
        .START_ADDR   (start_addr),
        .LENGTH       (length),
        .SRAM_DATA_IN (sram_din),
        .SRAM_ADDR    (sram_addr),
        .SRAM_OE_N    (oe_n),
        .MCU_RD       (mcu_rd),
        .MCU_DATA     (mcu_data),
        .DATA_RDY     (data_rdy),
        .BUSY         (busy),
`ifdef SRAM_READOUT_CHKSUM_EN
        .CHKSUM       (chksum),
`endif
        .DONE         (done)
    );

    sram_readout #(.ADDR_W(4), .WAIT_CYC(2)) dut_small (
        .CLK          (clk),
        .CLR          (clr_n),
        .START        (s_start),
        .START_ADDR   (s_start_addr),
        .LENGTH       (s_length),
        .SRAM_DATA_IN (s_din),
        .SRAM_ADDR    (s_addr),
        .SRAM_OE_N    (s_oe_n),
        .MCU_RD       (s_rd),
        .MCU_DATA     (s_data),
        .DATA_RDY     (s_rdy),
        .BUSY         (s_busy),
`ifdef SRAM_READOUT_CHKSUM_EN
        .CHKSUM       (s_chksum),
`endif
        .DONE         (s_done)
    );

    typedef struct {
        logic [18:0] sa;
        logic [18:0] len;
        logic [18:0] last_addr;
        logic [7:0]  first;
        logic [7:0]  last;
        logic [7:0]  chk;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(output bit ok);
        int n = 0;
        while (!data_rdy && n < 60) begin
            tick();
            n++;
        end
        ok = data_rdy;
        if (!ok) check("rdy_timeout", 32'(data_rdy), 32'd1);
    endtask

    task automatic ack();
        mcu_rd = 1'b1;
        repeat (4) tick();
        mcu_rd = 1'b0;
        tick();
    endtask

    task automatic do_readout(input logic [18:0] sa, input logic [18:0] len, input int n);
        bit ok;
        int lat;
        logic [18:0] ea;
        start_addr = sa;
        length     = len;
        start      = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!data_rdy && lat < 60) begin
            tick();
            lat++;
        end
        check("start_latency", 32'(lat), 32'd4);
        for (int i = 0; i < n; i++) begin
            wait_rdy(ok);
            if (!ok) return;
            ea = sa + 19'(i);
            check("byte_addr", 32'(sram_addr), 32'(ea));
            check("byte_data", 32'(mcu_data), 32'(mem[ea]));
            ack();
            check("ack_clears_rdy", 32'(data_rdy), 32'd0);
        end
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_oe_n", 32'(oe_n), 32'd1);
    endtask

    initial begin
        bit ok;
        bit stable;
        bit seen_low;
        int cnt;
        logic [7:0]  d0;
        logic [18:0] a0;

        for (int i = 0; i < 524288; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[19'h00010] = 8'hA1;
        mem[19'h00011] = 8'hB2;
        mem[19'h00012] = 8'hC3;
        mem[19'h00013] = 8'hD4;
        mem[19'h7FFFE] = 8'h11;
        mem[19'h7FFFF] = 8'h22;
        mem[19'h00000] = 8'h33;
        mem[19'h00001] = 8'h44;
        mem[19'h00200] = 8'hFF;
        mem[19'h00201] = 8'h02;
        mem[19'h00202] = 8'h10;

        vecs[0] = '{19'h00010, 19'd4, 19'h00013, 8'hA1, 8'hD4, 8'hEA};
        vecs[1] = '{19'h7FFFE, 19'd4, 19'h00001, 8'h11, 8'h44, 8'hAA};
        vecs[2] = '{19'h00200, 19'd3, 19'h00202, 8'hFF, 8'h10, 8'h11};
        vecs[3] = '{19'h00100, 19'd1, 19'h00100, 8'h5A, 8'h5A, 8'h5A};

        clr_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; mcu_rd = 1'b0;
        s_start = 1'b0; s_start_addr = '0; s_length = '0; s_rd = 1'b0;
        tick();
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_data", 32'(mcu_data), 32'd0);
        check("rst_rdy", 32'(data_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SRAM_READOUT_CHKSUM_EN
        check("rst_chksum", 32'(chksum), 32'd0);
`endif
        tick();
        clr_n = 1'b1;
        tick();

        // MCU_RD activity while idle must not start or pre-acknowledge anything
        repeat (3) begin
            mcu_rd = 1'b1; repeat (3) tick();
            mcu_rd = 1'b0; repeat (3) tick();
        end
        check("idle_rd_rdy", 32'(data_rdy), 32'd0);
        check("idle_rd_busy", 32'(busy), 32'd0);
        check("idle_rd_oe_n", 32'(oe_n), 32'd1);

        for (int v = 0; v < 4; v++) begin
            do_readout(vecs[v].sa, vecs[v].len, int'(vecs[v].len));
            check("vec_last_addr", 32'(sram_addr), 32'(vecs[v].last_addr));
            check("vec_last_data", 32'(mcu_data), 32'(vecs[v].last));
`ifdef SRAM_READOUT_CHKSUM_EN
            check("vec_chksum", 32'(chksum), 32'(vecs[v].chk));
`endif
            repeat (5) tick();
            check("fin_data_stable", 32'(mcu_data), 32'(vecs[v].last));
            check("fin_done_held", 32'(done), 32'd1);
        end

        // Withheld acknowledge plus a START while busy
        start_addr = 19'h00300; length = 19'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_rdy(ok);
        d0 = mcu_data; a0 = sram_addr;
        check("hold_first_data", 32'(d0), 32'(mem[19'h00300]));
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) begin start_addr = 19'h00555; length = 19'd9; start = 1'b1; end
            if (i == 11) start = 1'b0;
            tick();
            if (!data_rdy || mcu_data !== d0 || sram_addr !== a0 || !busy) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        mcu_rd = 1'b1;
        cnt = 0; seen_low = 1'b0;
        while (cnt < 40 && !(seen_low && data_rdy)) begin
            tick();
            cnt++;
            if (cnt == 4) mcu_rd = 1'b0;
            if (!data_rdy) seen_low = 1'b1;
        end
        mcu_rd = 1'b0;
        check("ack_to_rdy_latency", 32'(cnt), 32'd7);
        check("hold_second_addr", 32'(sram_addr), 32'h00301);
        check("hold_second_data", 32'(mcu_data), 32'(mem[19'h00301]));
        ack();
        check("hold_done", 32'(done), 32'd1);
        check("hold_last_addr", 32'(sram_addr), 32'h00301);

        // Reset during the third HOLD of an 8-byte readout
        start_addr = 19'h00100; length = 19'd8; start = 1'b1;
        tick();
        start = 1'b0;
        wait_rdy(ok); ack();
        wait_rdy(ok); ack();
        wait_rdy(ok);
        clr_n = 1'b0;
        #1;
        check("midrst_addr", 32'(sram_addr), 32'd0);
        check("midrst_oe_n", 32'(oe_n), 32'd1);
        check("midrst_data", 32'(mcu_data), 32'd0);
        check("midrst_rdy", 32'(data_rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        clr_n = 1'b1;
        tick();
        do_readout(19'h00100, 19'd8, 8);
        check("midrst_rerun_last", 32'(sram_addr), 32'h00107);

        // LENGTH=0 on a 4-bit address instance reads all 16 bytes
        s_start_addr = 4'd5; s_length = 4'd0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cnt = 0;
            while (!s_rdy && cnt < 60) begin tick(); cnt++; end
            check("small_rdy", 32'(s_rdy), 32'd1);
            check("small_data", 32'(s_data), 32'(8'hC0 | 8'((5 + i) & 15)));
            if (i == 15) check("small_not_done_early", 32'(s_done), 32'd0);
            s_rd = 1'b1; repeat (4) tick();
            s_rd = 1'b0; tick();
        end
        check("small_done", 32'(s_done), 32'd1);
        check("small_busy", 32'(s_busy), 32'd0);
        check("small_last_addr", 32'(s_addr), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
